led_pattern_sequencer: RTL and testbench
========================================

// Module: led_pattern_sequencer
// PURPOSE
//   Board-level controller for the green LED bank. Debounces two push keys.
//   Selects the blink mode and blink speed, and runs the tick divider.
//   Drives a registered 8-bit pattern onto LEDG. Sits directly between the
//   board pins (CLOCK_50, KEY, LEDG) and replaces ad-hoc per-LED blinkers.
// PARAMETERS
//   TICK_SLOW  25_000_000  clock cycles per pattern step, slow speed (2 Hz @ 50 MHz)
//   TICK_FAST   2_500_000  clock cycles per pattern step, fast speed (must be < TICK_SLOW)
//   DEBOUNCE    1_000_000  consecutive stable cycles needed to accept a key level
// PORTS
//   CLOCK_50  in   1  system clock; the only clock
//   RESET     in   1  synchronous, active-high reset
//   KEY       in   2  raw active-low keys; KEY[0]=mode advance, KEY[1]=speed toggle
//   LEDG      out  8  registered LED pattern, 1 = lit
//   MODE      out  2  current mode encoding (debug/HEX display)
//   FAST      out  1  1 = fast speed selected
// BEHAVIOUR
//   Reset (RESET=1 at posedge): LEDG=8'h00, MODE=OFF, FAST=0, tick counter=0.
//     Both debouncers are set to the released state (1), with counters at 0.
//     Reset mid-operation aborts everything; a held key is not seen as a press
//     until it is released and pressed again.
//   Key path: 2-FF synchronizer, then debounce. Debounced level changes only
//     after DEBOUNCE consecutive cycles at the new synchronized level. Any
//     bounce restarts the count. A press pulse is 1 cycle, on debounced 1->0.
//     Release makes no pulse. Latency from KEY edge to pulse = 2+DEBOUNCE cycles.
//   Speed: each KEY[1] press pulse toggles FAST.
//   Tick divider: P = FAST ? TICK_FAST : TICK_SLOW. Counter runs 0..P-1.
//     tick=1 in the cycle where count==P-1, and count wraps to 0.
//     The counter width is $clog2(TICK_SLOW).
//     On a speed toggle or mode change the counter clears to 0; no tick fires.
//   Mode FSM: OFF(0) -> BLINK(1) -> ALT(2) -> CHASE(3) -> OFF, one step per KEY[0]
//     press pulse. On entering a mode, LEDG loads its initial pattern on the
//     next clock edge (1-cycle latency):
//       OFF   : 8'h00, no change on tick
//       BLINK : 8'h00, on tick LEDG <= ~LEDG (all 8 toggle)
//       ALT   : 8'h55, on tick LEDG <= ~LEDG (55/AA alternate)
//       CHASE : 8'h01, on tick rotate left; 8'h80 -> 8'h01 wrap
//   Simultaneous events:
//     mode pulse + tick in the same cycle: mode change wins and the tick is dropped.
//     mode pulse + speed pulse in the same cycle: both are applied, and the counter clears.
//     speed pulse + tick in the same cycle: the speed change wins, so the pattern holds.
//   Width rule: compare count against P-1 computed at counter width; no truncation.
// STRUCTURE
//   led_pkg: mode encodings MODE_OFF/BLINK/ALT/CHASE (2 bits), initial patterns
//     PAT_OFF=8'h00, PAT_BLINK=8'h00, PAT_ALT=8'h55, PAT_CHASE=8'h01.
//   Sub-module key_debounce (#DEBOUNCE): raw_n in -> synchronizer + stable counter
//     -> level, press_pulse out. It is instantiated twice.
//   The top level holds the mode FSM, speed flag, tick divider and pattern register.
// TESTING  (bench overrides: TICK_SLOW=20, TICK_FAST=4, DEBOUNCE=3)
//   1. Reset held 5 cycles, then released, keys idle high ->
//      LEDG=00, MODE=0, FAST=0 for 100 cycles.
//   2. KEY[0] low for 10 cycles -> one press pulse 5 cycles after the edge.
//      MODE=1, LEDG=00, then toggles 00/FF every 20 cycles.
//   3. Two more clean KEY[0] presses -> MODE=3, LEDG=01.
//      Steps 02,04..80 every 20 cycles, then 80->01 wraps.
//   4. KEY[0] bounces 0,1,0,1 on single cycles, then stays low 10 cycles ->
//      exactly one mode advance.
//   5. In ALT, press KEY[1] -> FAST=1, counter cleared; 55/AA alternate every
//      4 cycles. Press it again -> back to every 20 cycles.
//   6. Assert RESET while in CHASE with KEY[0] held low ->
//      LEDG=00, MODE=0 next cycle. No advance until the key is released and pressed again.

Source files
------------

// File: rtl/led_pattern_sequencer_pkg.sv
// Shared encodings and pattern helpers for the green LED bank sequencer.
package led_pattern_sequencer_pkg;

  localparam int unsigned LED_W     = 8;
  localparam int unsigned KEY_W     = 2;
  localparam int unsigned MODE_W    = 2;
  localparam int unsigned KEY_MODE  = 0;
  localparam int unsigned KEY_SPEED = 1;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF   = 2'd0,
    MODE_BLINK = 2'd1,
    MODE_ALT   = 2'd2,
    MODE_CHASE = 2'd3
  } mode_e;

  localparam logic [LED_W-1:0] PAT_OFF   = 8'h00;
  localparam logic [LED_W-1:0] PAT_BLINK = 8'h00;
  localparam logic [LED_W-1:0] PAT_ALT   = 8'h55;
  localparam logic [LED_W-1:0] PAT_CHASE = 8'h01;

  // Mode order wraps CHASE back to OFF.
  function automatic mode_e next_mode(input mode_e m);
    mode_e r;
    case (m)
      MODE_OFF:   r = MODE_BLINK;
      MODE_BLINK: r = MODE_ALT;
      MODE_ALT:   r = MODE_CHASE;
      MODE_CHASE: r = MODE_OFF;
      default:    r = MODE_OFF;
    endcase
    return r;
  endfunction

  function automatic logic [LED_W-1:0] init_pattern(input mode_e m);
    logic [LED_W-1:0] r;
    case (m)
      MODE_OFF:   r = PAT_OFF;
      MODE_BLINK: r = PAT_BLINK;
      MODE_ALT:   r = PAT_ALT;
      MODE_CHASE: r = PAT_CHASE;
      default:    r = PAT_OFF;
    endcase
    return r;
  endfunction

  // Pattern advance applied on each divider tick.
  function automatic logic [LED_W-1:0] step_pattern(input mode_e m, input logic [LED_W-1:0] p);
    logic [LED_W-1:0] r;
    case (m)
      MODE_OFF:   r = p;
      MODE_BLINK: r = ~p;
      MODE_ALT:   r = ~p;
      MODE_CHASE: r = {p[LED_W-2:0], p[LED_W-1]};
      default:    r = p;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Board-side pin bundle: raw keys in, LED pattern and status out.
interface led_pattern_sequencer_if;
  import led_pattern_sequencer_pkg::*;

  logic [KEY_W-1:0]  KEY;
  logic [LED_W-1:0]  LEDG;
  logic [MODE_W-1:0] MODE;
  logic              FAST;

  modport master (output KEY, input LEDG, input MODE, input FAST);
  modport slave  (input KEY, output LEDG, output MODE, output FAST);
endinterface

// File: rtl/led_pattern_sequencer_key_debounce.sv
// Synchronizes and debounces one active-low key; one-cycle pulse on each accepted press.
module key_debounce #(
  parameter int unsigned DEBOUNCE = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  output logic level,
  output logic press_pulse
);

  localparam int unsigned CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] cnt;
  logic             armed;

  // Synchronizer runs through reset so a held key is already visible afterwards.
  always_ff @(posedge clk) begin
    sync_1 <= raw_n;
    sync_2 <= sync_1;
  end

  // Armed only once the key has been seen released, so a key held across reset never pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      level       <= 1'b1;
      cnt         <= '0;
      armed       <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      if (level && sync_2) begin
        armed <= 1'b1;
      end
      if (sync_2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level       <= sync_2;
        cnt         <= '0;
        press_pulse <= ~sync_2 & armed;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Green LED bank controller: key debounce, mode FSM, speed flag, tick divider, pattern register.
module led_pattern_sequencer
  import led_pattern_sequencer_pkg::*;
#(
  parameter int unsigned TICK_SLOW = 25_000_000,
  parameter int unsigned TICK_FAST = 2_500_000,
  parameter int unsigned DEBOUNCE  = 1_000_000
) (
  input logic                     CLOCK_50,
  input logic                     RESET,
  led_pattern_sequencer_if.slave  bus
);

  localparam int unsigned TICK_W = (TICK_SLOW > 1) ? $clog2(TICK_SLOW) : 1;
  localparam logic [TICK_W-1:0] SLOW_LAST = TICK_W'(TICK_SLOW - 1);
  localparam logic [TICK_W-1:0] FAST_LAST = TICK_W'(TICK_FAST - 1);

  logic              mode_pulse;
  logic              speed_pulse;
  logic [KEY_W-1:0]  unused_key_level;

  mode_e             mode_q, mode_d;
  logic              fast_q, fast_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [LED_W-1:0]  ledg_q, ledg_d;
  logic              tick_c;

  key_debounce #(.DEBOUNCE(DEBOUNCE)) u_mode_key (
    .clk         (CLOCK_50),
    .rst         (RESET),
    .raw_n       (bus.KEY[KEY_MODE]),
    .level       (unused_key_level[KEY_MODE]),
    .press_pulse (mode_pulse)
  );

  key_debounce #(.DEBOUNCE(DEBOUNCE)) u_speed_key (
    .clk         (CLOCK_50),
    .rst         (RESET),
    .raw_n       (bus.KEY[KEY_SPEED]),
    .level       (unused_key_level[KEY_SPEED]),
    .press_pulse (speed_pulse)
  );

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      mode_q     <= MODE_OFF;
      fast_q     <= 1'b0;
      tick_cnt_q <= '0;
      ledg_q     <= PAT_OFF;
    end else begin
      mode_q     <= mode_d;
      fast_q     <= fast_d;
      tick_cnt_q <= tick_cnt_d;
      ledg_q     <= ledg_d;
    end
  end

  // Priority: mode change, then speed change, then tick; any key event restarts the divider.
  always_comb begin
    mode_d     = mode_q;
    fast_d     = fast_q ^ speed_pulse;
    tick_cnt_d = tick_cnt_q + TICK_W'(1);
    ledg_d     = ledg_q;
    tick_c     = (tick_cnt_q == (fast_q ? FAST_LAST : SLOW_LAST));

    if (mode_pulse) begin
      mode_d     = next_mode(mode_q);
      ledg_d     = init_pattern(mode_d);
      tick_cnt_d = '0;
    end else if (speed_pulse) begin
      tick_cnt_d = '0;
    end else if (tick_c) begin
      ledg_d     = step_pattern(mode_q, ledg_q);
      tick_cnt_d = '0;
    end
  end

  assign bus.LEDG = ledg_q;
  assign bus.MODE = mode_q;
  assign bus.FAST = fast_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench: cycle-level reference model feeds expectations, negedge monitor compares.
module tb_led_pattern_sequencer;

  localparam int TS = 20;
  localparam int TF = 4;
  localparam int DB = 3;

  typedef struct packed {
    logic [7:0] led;
    logic [1:0] mode;
    logic       fast;
  } exp_t;

  typedef struct {
    int         kind;
    logic [7:0] val;
    string      name;
  } spot_t;

  logic clk;
  logic rst;
  led_pattern_sequencer_if bus ();

  led_pattern_sequencer #(.TICK_SLOW(TS), .TICK_FAST(TF), .DEBOUNCE(DB)) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t  expq[$];
  spot_t spotq[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model state
  logic [1:0] raw_hist[$];
  int         mode_m = 0;
  int         cnt_m = 0;
  logic       fast_m = 1'b0;
  logic [7:0] led_m = 8'h00;
  logic       lvl_m[2] = '{1'b1, 1'b1};
  logic       armed_m[2] = '{1'b0, 1'b0};
  logic       pulse_m[2] = '{1'b0, 1'b0};
  int         run_m[2] = '{0, 0};

  function automatic logic [7:0] init_led(input int m);
    case (m)
      2: return 8'h55;
      3: return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] step_led(input int m, input logic [7:0] p);
    case (m)
      1, 2: return ~p;
      3: return (p == 8'h80) ? 8'h01 : 8'(p * 2);
      default: return p;
    endcase
  endfunction

  // Model: one step per rising edge using the same sampled inputs as the DUT
  always @(posedge clk) begin
    int   per;
    logic tick, pm, ps, syn;
    raw_hist.push_back(bus.KEY);
    if (raw_hist.size() > 3) void'(raw_hist.pop_front());
    pm   = pulse_m[0];
    ps   = pulse_m[1];
    per  = fast_m ? TF : TS;
    tick = (cnt_m == per - 1);
    if (rst) begin
      mode_m = 0; cnt_m = 0; fast_m = 1'b0; led_m = 8'h00;
      for (int k = 0; k < 2; k++) begin
        lvl_m[k] = 1'b1; armed_m[k] = 1'b0; pulse_m[k] = 1'b0; run_m[k] = 0;
      end
    end else begin
      if (pm) begin
        mode_m = (mode_m + 1) % 4;
        led_m  = init_led(mode_m);
      end else if (!ps && tick) begin
        led_m = step_led(mode_m, led_m);
      end
      if (ps) fast_m = !fast_m;
      cnt_m = (pm || ps || tick) ? 0 : cnt_m + 1;
      for (int k = 0; k < 2; k++) begin
        syn = (raw_hist.size() == 3) ? raw_hist[0][k] : 1'b1;
        pulse_m[k] = 1'b0;
        if (lvl_m[k] && syn) armed_m[k] = 1'b1;
        if (syn == lvl_m[k]) run_m[k] = 0;
        else begin
          run_m[k] = run_m[k] + 1;
          if (run_m[k] == DB) begin
            lvl_m[k]   = syn;
            run_m[k]   = 0;
            pulse_m[k] = !syn && armed_m[k];
          end
        end
      end
    end
    expq.push_back('{led: led_m, mode: 2'(mode_m), fast: fast_m});
  end

  // Monitor: every falling edge, compare outputs to the model and to queued spot checks
  always @(negedge clk) begin
    exp_t       e;
    spot_t      s;
    logic [7:0] act;
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty t=%0t no expectation queued", $time);
    end else begin
      e = expq.pop_front();
      if ({bus.LEDG, bus.MODE, bus.FAST} !== e) begin
        errors++;
        $display("FAIL cycle_compare t=%0t actual ledg=%h mode=%0d fast=%0b required ledg=%h mode=%0d fast=%0b",
                 $time, bus.LEDG, bus.MODE, bus.FAST, e.led, e.mode, e.fast);
      end
    end
    while (spotq.size() > 0) begin
      s = spotq.pop_front();
      checks++;
      case (s.kind)
        0: act = 8'(bus.MODE);
        1: act = 8'(bus.FAST);
        default: act = bus.LEDG;
      endcase
      if (s.kind == 3) begin
        if (act != 8'h55 && act != 8'hAA) begin
          errors++;
          $display("FAIL %s t=%0t actual ledg=%h required 55 or aa", s.name, $time, act);
        end
      end else if (act !== s.val) begin
        errors++;
        $display("FAIL %s t=%0t actual=%h required=%h", s.name, $time, act, s.val);
      end
    end
  end

  task automatic spot(input int kind, input logic [7:0] val, input string name);
    spotq.push_back('{kind, val, name});
  endtask

  task automatic hold(input logic [1:0] k, input int n);
    bus.KEY = k;
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int idx);
    hold((idx == 0) ? 2'b10 : 2'b01, 10);
    hold(2'b11, 10);
  endtask

  initial begin
    rst = 1'b1;
    hold(2'b11, 5);
    rst = 1'b0;
    hold(2'b11, 100);
    spot(0, 8'd0, "idle_mode");
    spot(1, 8'd0, "idle_fast");
    spot(2, 8'h00, "idle_ledg");

    // BLINK: still 00 shortly after entry, FF after the first 20-cycle tick
    hold(2'b10, 10);
    hold(2'b11, 10);
    spot(0, 8'd1, "blink_mode");
    spot(2, 8'h00, "blink_initial");
    hold(2'b11, 10);
    spot(2, 8'hFF, "blink_toggled");
    hold(2'b11, 60);

    // Through ALT into CHASE, then let the chase wrap
    press(0);
    press(0);
    spot(0, 8'd3, "chase_mode");
    spot(2, 8'h01, "chase_initial");
    hold(2'b11, 200);

    // Bouncy press: exactly one advance (CHASE -> OFF)
    hold(2'b10, 1); hold(2'b11, 1); hold(2'b10, 1); hold(2'b11, 1);
    hold(2'b10, 10);
    hold(2'b11, 10);
    spot(0, 8'd0, "bounce_single_advance");

    // ALT with speed toggles
    press(0);
    press(0);
    spot(0, 8'd2, "alt_mode");
    spot(3, 8'h00, "alt_pattern");
    press(1);
    spot(1, 8'd1, "fast_on");
    spot(3, 8'h00, "alt_fast_pattern");
    hold(2'b11, 40);
    press(1);
    spot(1, 8'd0, "fast_off");
    hold(2'b11, 40);

    // Reset in CHASE with KEY[0] held: no advance until released and pressed again
    press(0);
    spot(0, 8'd3, "chase_before_reset");
    hold(2'b10, 10);
    rst = 1'b1;
    hold(2'b10, 2);
    rst = 1'b0;
    hold(2'b10, 30);
    spot(0, 8'd0, "held_key_after_reset");
    spot(2, 8'h00, "ledg_after_reset");
    hold(2'b11, 10);
    spot(0, 8'd0, "release_no_advance");
    press(0);
    spot(0, 8'd1, "repress_advances");

    // Randomized key activity with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        hold(2'(($urandom)), $urandom_range(1, 3));
        rst = 1'b0;
      end
      hold(2'($urandom), $urandom_range(1, 12));
    end

    hold(2'b11, 5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
